uart_tx_queue: RTL and testbench

//  Byte FIFO plus frame pacer that sits directly upstream of uart_transmitter.

---
 rtl/uart_tx_queue_if.sv | 26 ++
 rtl/uart_tx_queue.sv | 115 +++++++++++
 tb/tb_uart_tx_queue.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_queue_if.sv
// Producer/baud-tick side and status of the UART transmit queue, bundled for one port.
interface uart_tx_queue_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic                  wr_en;
   logic [7:0]            wr_data;
   logic                  clr_ovf;
   logic                  tx_clk_en;
   logic                  tx_en;
   logic [7:0]            tx_data;
   logic                  full;
   logic                  empty;
   logic [DEPTH_LOG2:0]   level;
   logic                  overflow;
   logic                  busy;

   modport master (
      output wr_en, wr_data, clr_ovf, tx_clk_en,
      input  tx_en, tx_data, full, empty, level, overflow, busy
   );

   modport slave (
      input  wr_en, wr_data, clr_ovf, tx_clk_en,
      output tx_en, tx_data, full, empty, level, overflow, busy
   );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO pacing one UART frame at a time; head pops and tx_en rises the cycle after empty clears.
// Writes are never stalled: a write while full is dropped and latches a sticky overflow flag.
module uart_tx_queue #(
   parameter int DEPTH_LOG2  = 4,
   parameter int FRAME_TICKS = 10,
   parameter int GUARD_TICKS = 1
) (
   input logic            sys_clk,
   input logic            rst,
   uart_tx_queue_if.slave bus
);
   localparam int DEPTH     = 1 << DEPTH_LOG2;
   localparam int LW        = DEPTH_LOG2 + 1;
   localparam int LAST_TICK = FRAME_TICKS + GUARD_TICKS - 1;
   localparam int CW        = $clog2(FRAME_TICKS + GUARD_TICKS + 1);

   typedef enum logic [1:0] {IDLE, ARM, SEND} state_t;

   state_t                state, state_nx;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
   logic [LW-1:0]         level_q, level_nx;
   logic                  full_q, empty_q, overflow_q;
   logic                  tx_en_q, tx_en_nx;
   logic [7:0]            tx_data_q;
   logic [CW-1:0]         cnt, cnt_nx;
   logic                  push, pop;

   // Acceptance uses the registered full flag, so a same-cycle pop never frees room for a write.
   assign push     = bus.wr_en && !full_q;
   assign level_nx = level_q + LW'(push) - LW'(pop);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      tx_en_nx = tx_en_q;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            if (!empty_q) begin
               pop      = 1'b1;
               tx_en_nx = 1'b1;
               state_nx = ARM;
            end
         end
         ARM: begin
            // The tick that samples tx_en is tick 1 of the frame.
            if (bus.tx_clk_en) begin
               tx_en_nx = 1'b0;
               cnt_nx   = CW'(1);
               state_nx = SEND;
            end
         end
         SEND: begin
            if (bus.tx_clk_en) begin
               if (cnt == CW'(LAST_TICK)) begin
                  cnt_nx   = '0;
                  state_nx = IDLE;
               end else begin
                  cnt_nx = cnt + CW'(1);
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         tx_en_q    <= 1'b0;
         tx_data_q  <= 8'h00;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         tx_en_q <= tx_en_nx;
         if (pop) begin
            tx_data_q <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + DEPTH_LOG2'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         end
         level_q <= level_nx;
         full_q  <= (level_nx == LW'(DEPTH));
         empty_q <= (level_nx == '0);
         if (bus.wr_en && full_q) begin
            overflow_q <= 1'b1;
         end else if (bus.clr_ovf) begin
            overflow_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.wr_data;
      end
   end

   assign bus.tx_en    = tx_en_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.full     = full_q;
   assign bus.empty    = empty_q;
   assign bus.level    = level_q;
   assign bus.overflow = overflow_q;
   assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed and randomized checks of uart_tx_queue against a queue-based frame model.
module tb_uart_tx_queue;
   localparam int DEPTH = 16;
   localparam int FRAME = 11;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_queue_if #(.DEPTH_LOG2(4)) bus ();

   uart_tx_queue #(
      .DEPTH_LOG2 (4),
      .FRAME_TICKS(10),
      .GUARD_TICKS(1)
   ) dut (
      .sys_clk(clk),
      .rst    (rst),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model: queued bytes, the byte on the line, and how many ticks of its frame have elapsed.
   logic [7:0] m_q[$];
   logic [7:0] m_pops[$];
   logic [7:0] d_pops[$];
   bit         m_sending = 1'b0;
   bit         m_ovf     = 1'b0;
   int         m_ticks   = 0;
   logic [7:0] m_data    = 8'h00;

   int tick_period = 0;
   int tick_phase  = 0;
   bit prev_tx_en  = 1'b0;
   int max_level   = 0;
   int tx_en_rises = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc(input bit w, input logic [7:0] d, input bit c, input bit r);
      bit t;
      bit was_full;
      bit was_empty;
      t = (tick_period != 0) && (tick_phase == 0);
      if (tick_period != 0) tick_phase = (tick_phase + 1) % tick_period;
      rst           = r;
      bus.wr_en     = w;
      bus.wr_data   = d;
      bus.clr_ovf   = c;
      bus.tx_clk_en = t;
      @(posedge clk);
      if (r) begin
         m_q.delete();
         m_sending = 1'b0;
         m_ticks   = 0;
         m_data    = 8'h00;
         m_ovf     = 1'b0;
      end else begin
         was_full  = (m_q.size() == DEPTH);
         was_empty = (m_q.size() == 0);
         if (!m_sending && !was_empty) begin
            m_data = m_q.pop_front();
            m_pops.push_back(m_data);
            m_sending = 1'b1;
            m_ticks   = 0;
         end else if (m_sending && t) begin
            m_ticks++;
            if (m_ticks == FRAME) m_sending = 1'b0;
         end
         if (w && was_full) m_ovf = 1'b1;
         else if (c) m_ovf = 1'b0;
         if (w && !was_full) m_q.push_back(d);
      end
      #1;
      check("tx_en",    bus.tx_en,    (m_sending && m_ticks == 0));
      check("tx_data",  bus.tx_data,  m_data);
      check("level",    bus.level,    m_q.size());
      check("empty",    bus.empty,    (m_q.size() == 0));
      check("full",     bus.full,     (m_q.size() == DEPTH));
      check("overflow", bus.overflow, m_ovf);
      check("busy",     bus.busy,     m_sending);
      if (bus.tx_en === 1'b1 && !prev_tx_en) begin
         d_pops.push_back(bus.tx_data);
         tx_en_rises++;
      end
      prev_tx_en = (bus.tx_en === 1'b1);
      if (int'(bus.level) > max_level) max_level = int'(bus.level);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic drain(input int maxc);
      int k;
      k = 0;
      while ((m_q.size() != 0 || m_sending) && k < maxc) begin
         cyc(1'b0, 8'h00, 1'b0, 1'b0);
         k++;
      end
      check("drain_in_budget", (m_q.size() == 0 && !m_sending), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int s, k, seen, rises0;
      logic [7:0] b;

      // Reset
      tick_period = 0;
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      check("rst_tx_data", bus.tx_data, 8'h00);
      check("rst_empty", bus.empty, 1);

      // 1: single byte, tick every 16 clocks
      tick_period = 16;
      tick_phase  = 5;
      cyc(1'b1, 8'h55, 1'b0, 1'b0);
      check("t1_no_tx_yet", bus.tx_en, 0);
      idle(1);
      check("t1_tx_en_rise", bus.tx_en, 1);
      drain(400);
      check("t1_byte", d_pops[d_pops.size()-1], 8'h55);
      check("t1_tx_data_held", bus.tx_data, 8'h55);

      // 2: burst of five
      tick_period = 4;
      tick_phase  = 0;
      max_level   = 0;
      s = d_pops.size();
      for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
      drain(600);
      check("t2_peak_level", max_level, 4);
      check("t2_frames", d_pops.size() - s, 5);

      // 3: overflow with ticks stalled
      tick_period = 0;
      for (int i = 0; i < 17; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      check("t3_full", bus.full, 1);
      check("t3_ovf_clear_before", bus.overflow, 0);
      cyc(1'b1, 8'hEE, 1'b0, 1'b0);
      check("t3_ovf_set", bus.overflow, 1);
      cyc(1'b1, 8'hEE, 1'b1, 1'b0);
      check("t3_set_wins", bus.overflow, 1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("t3_ovf_cleared", bus.overflow, 0);
      tick_period = 2;
      tick_phase  = 0;
      drain(800);
      seen = 0;
      foreach (d_pops[i]) if (d_pops[i] == 8'hEE) seen++;
      check("t3_dropped_absent", seen, 0);

      // 4: forty incrementing bytes through the wrapping pointers
      tick_period = 1;
      s = d_pops.size();
      k = 0;
      for (int c = 0; c < 3000 && k < 40; c++) begin
         if (m_q.size() < 12 && $urandom_range(0, 1) == 1) begin
            cyc(1'b1, 8'h40 + 8'(k), 1'b0, 1'b0);
            k++;
         end else begin
            idle(1);
         end
      end
      drain(800);
      check("t4_count", d_pops.size() - s, 40);
      for (int i = 0; i < 40; i++) begin
         b = (s + i < d_pops.size()) ? d_pops[s+i] : 8'hxx;
         check("t4_seq", b, 8'h40 + 8'(i));
      end

      // 5: write on the IDLE pop cycle with three bytes queued
      tick_period = 0;
      s = d_pops.size();
      for (int i = 1; i <= 4; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      idle(2);
      check("t5_level_before", bus.level, 3);
      tick_period = 1;
      k = 0;
      do begin
         idle(1);
         k++;
      end while (m_sending && k < 50);
      check("t5_frame_done", bus.busy, 0);
      cyc(1'b1, 8'hC5, 1'b0, 1'b0);
      check("t5_level_kept", bus.level, 3);
      drain(200);
      for (int i = 0; i < 5; i++) begin
         b = (s + i < d_pops.size()) ? d_pops[s+i] : 8'hxx;
         check("t5_order", b, 8'hC1 + 8'(i));
      end

      // 6: reset in the middle of a frame
      tick_period = 0;
      for (int i = 1; i <= 4; i++) cyc(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
      idle(2);
      tick_period = 2;
      tick_phase  = 0;
      k = 0;
      while (m_ticks < 5 && k < 100) begin
         idle(1);
         k++;
      end
      check("t6_mid_frame", bus.busy, 1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      check("t6_tx_en", bus.tx_en, 0);
      check("t6_busy", bus.busy, 0);
      check("t6_level", bus.level, 0);
      check("t6_empty", bus.empty, 1);
      rises0 = tx_en_rises;
      idle(60);
      check("t6_no_more_tx", tx_en_rises - rises0, 0);

      // Randomized traffic
      tick_period = $urandom_range(1, 3);
      tick_phase  = 0;
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 9) < 3), 8'($urandom), ($urandom_range(0, 19) == 0), 1'b0);
      end
      drain(2000);

      // Whole-run order scoreboard
      check("pop_count", d_pops.size(), m_pops.size());
      for (int i = 0; i < m_pops.size(); i++) begin
         b = (i < d_pops.size()) ? d_pops[i] : 8'hxx;
         check("pop_order", b, m_pops[i]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
